// File: rtl/step_pkg.sv
// Shared types and coil pattern tables for the stepper phase sequencer.
// Define HALF_STEP_EN to select the 8-entry half-step table instead of full-step.
package step_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DWELL = 1'b1
    } state_t;

    // Entry i lives at bits [4*i +: 4]
    localparam logic [15:0] FULL_STEP_TABLE = {4'b1001, 4'b0011, 4'b0110, 4'b1100};
    localparam logic [31:0] HALF_STEP_TABLE = {4'b1001, 4'b0001, 4'b0011, 4'b0010,
                                               4'b0110, 4'b0100, 4'b1100, 4'b1000};

`ifdef HALF_STEP_EN
    localparam int TABLE_LEN = 8;
    localparam int IDX_W     = 3;
`else
    localparam int TABLE_LEN = 4;
    localparam int IDX_W     = 2;
`endif

endpackage

// File: rtl/step_phase_lut.sv
// Combinational phase index to coil pattern lookup with enable gating.
// Table selection follows HALF_STEP_EN from step_pkg.
module step_phase_lut
    import step_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic             enable,
    output logic [3:0]       coil
);

    always_comb begin
        coil = 4'b0000;
        if (enable) begin
`ifdef HALF_STEP_EN
            coil = HALF_STEP_TABLE[{idx, 2'b00} +: 4];
`else
            coil = FULL_STEP_TABLE[{idx, 2'b00} +: 4];
`endif
        end
    end

endmodule

// File: rtl/step_phase_sequencer.sv
// Turns step request pulses into a stepper coil sequence with a minimum dwell,
// one-deep request buffering, signed position and a sticky overrun flag (HALF_STEP_EN selects half-step).
module step_phase_sequencer
    import step_pkg::*;
#(
    parameter int DWELL_CYCLES = 50000,
    parameter int CNT_W        = 16,
    parameter int POS_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_pulse,
    input  logic             dir,
    input  logic             enable,
    input  logic             clr_ovr,
    output logic [3:0]       coil,
    output logic [POS_W-1:0] position,
    output logic             busy,
    output logic             step_done,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL_CYCLES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pend_q, pend_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic               ovr_d;
    logic               advance;
    logic               drop;
    logic [3:0]         coil_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        advance = 1'b0;
        drop    = 1'b0;

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (step_pulse) begin
                        advance = 1'b1;
                        cnt_d   = RELOAD;
                        state_d = DWELL;
                    end
                end
                DWELL: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                        if (step_pulse) begin
                            if (pend_q) drop = 1'b1;
                            else        pend_d = 1'b1;
                        end
                    end else if (pend_q || step_pulse) begin
                        // Pending goes first; a simultaneous new pulse takes its slot
                        advance = 1'b1;
                        cnt_d   = RELOAD;
                        pend_d  = pend_q && step_pulse;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        idx_d = idx_q;
        pos_d = pos_q;
        if (advance) begin
            idx_d = dir ? idx_q + IDX_W'(1) : idx_q - IDX_W'(1);
            pos_d = dir ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
        end
        ovr_d = drop ? 1'b1 : (clr_ovr ? 1'b0 : overrun);
    end

    step_phase_lut u_lut (
        .idx    (idx_d),
        .enable (enable),
        .coil   (coil_d)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            idx_q     <= '0;
            pos_q     <= '0;
            coil      <= 4'b0000;
            step_done <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            idx_q     <= idx_d;
            pos_q     <= pos_d;
            coil      <= coil_d;
            step_done <= advance;
            overrun   <= ovr_d;
        end
    end

    assign position = pos_q;
    assign busy     = (state_q == DWELL);

endmodule
